// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs
//  Description : ALU reservation station. Holds up to RS_DEPTH decoded ALU
//                ops, snoops ALU/LS result broadcasts to capture operands by
//                rename tag, and issues the lowest-index ready op into a
//                registered issue slot toward the ALU.
//  Ports       : clk, rst (async, active low)
//                dispatch : dispEn, dispOp, dispDataO/TagO, dispDataT/TagT,
//                           dispDestTag, dispDestName -> rsFull
//                snoop    : ALUwrtEn/Tag/Data, LSwrtEn/Tag/Data
//                issue    : aluReady -> aluEn, aluOp, aluA, aluB,
//                           aluDestTag, aluDestName
//  Revision    : 1.0  initial release
// ============================================================================
module alu_rs #(
    parameter int                RS_DEPTH = 8,
    parameter int                DATA_W   = 32,
    parameter int                TAG_W    = 4,
    parameter int                OP_W     = 6,
    parameter int                NAME_W   = 5,
    parameter logic [TAG_W-1:0]  TAG_FREE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispEn,
    input  logic [OP_W-1:0]   dispOp,
    input  logic [DATA_W-1:0] dispDataO,
    input  logic [TAG_W-1:0]  dispTagO,
    input  logic [DATA_W-1:0] dispDataT,
    input  logic [TAG_W-1:0]  dispTagT,
    input  logic [TAG_W-1:0]  dispDestTag,
    input  logic [NAME_W-1:0] dispDestName,
    output logic              rsFull,
    input  logic              ALUwrtEn,
    input  logic [TAG_W-1:0]  ALUwrtTag,
    input  logic [DATA_W-1:0] ALUwrtData,
    input  logic              LSwrtEn,
    input  logic [TAG_W-1:0]  LSwrtTag,
    input  logic [DATA_W-1:0] LSwrtData,
    input  logic              aluReady,
    output logic              aluEn,
    output logic [OP_W-1:0]   aluOp,
    output logic [DATA_W-1:0] aluA,
    output logic [DATA_W-1:0] aluB,
    output logic [TAG_W-1:0]  aluDestTag,
    output logic [NAME_W-1:0] aluDestName
);

    localparam int c_IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RS_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RS_DEPTH);

    // Entry storage
    logic [RS_DEPTH-1:0] r_valid_q, w_valid_d;
    logic [OP_W-1:0]     r_op_q    [RS_DEPTH];
    logic [OP_W-1:0]     w_op_d    [RS_DEPTH];
    logic [DATA_W-1:0]   r_vo_q    [RS_DEPTH];
    logic [DATA_W-1:0]   w_vo_d    [RS_DEPTH];
    logic [TAG_W-1:0]    r_qo_q    [RS_DEPTH];
    logic [TAG_W-1:0]    w_qo_d    [RS_DEPTH];
    logic [DATA_W-1:0]   r_vt_q    [RS_DEPTH];
    logic [DATA_W-1:0]   w_vt_d    [RS_DEPTH];
    logic [TAG_W-1:0]    r_qt_q    [RS_DEPTH];
    logic [TAG_W-1:0]    w_qt_d    [RS_DEPTH];
    logic [TAG_W-1:0]    r_dtag_q  [RS_DEPTH];
    logic [TAG_W-1:0]    w_dtag_d  [RS_DEPTH];
    logic [NAME_W-1:0]   r_dname_q [RS_DEPTH];
    logic [NAME_W-1:0]   w_dname_d [RS_DEPTH];

    // Occupancy
    logic [c_CNT_W-1:0]  r_count_q, w_count_d;
    logic                r_full_q, w_full_d;

    // Issue slot
    logic                r_alu_en_q, w_alu_en_d;
    logic [OP_W-1:0]     r_alu_op_q, w_alu_op_d;
    logic [DATA_W-1:0]   r_alu_a_q, w_alu_a_d;
    logic [DATA_W-1:0]   r_alu_b_q, w_alu_b_d;
    logic [TAG_W-1:0]    r_alu_dtag_q, w_alu_dtag_d;
    logic [NAME_W-1:0]   r_alu_dname_q, w_alu_dname_d;

    // Control
    logic [RS_DEPTH-1:0] w_ready;
    logic                w_alu_hit, w_ls_hit;
    logic                w_load_ok, w_iss_found, w_issue;
    logic [c_IDX_W-1:0]  w_iss_idx;
    logic                w_alloc_found, w_accept;
    logic [c_IDX_W-1:0]  w_alloc_idx;
    logic [DATA_W-1:0]   w_disp_vo, w_disp_vt;
    logic [TAG_W-1:0]    w_disp_qo, w_disp_qt;

    // Returns {data, tag} after applying broadcasts to one operand. ALU is
    // checked last so that it wins if both buses carry the same tag.
    function automatic logic [DATA_W+TAG_W-1:0] f_snoop(
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] data,
        input logic              alu_hit,
        input logic [TAG_W-1:0]  alu_tag,
        input logic [DATA_W-1:0] alu_data,
        input logic              ls_hit,
        input logic [TAG_W-1:0]  ls_tag,
        input logic [DATA_W-1:0] ls_data
    );
        logic [DATA_W+TAG_W-1:0] res;
        res = {data, tag};
        if (ls_hit && (tag == ls_tag)) begin
            res = {ls_data, TAG_FREE};
        end
        if (alu_hit && (tag == alu_tag)) begin
            res = {alu_data, TAG_FREE};
        end
        return res;
    endfunction

    // A broadcast carrying TAG_FREE must never match a waiting operand.
    assign w_alu_hit = ALUwrtEn && (ALUwrtTag != TAG_FREE);
    assign w_ls_hit  = LSwrtEn  && (LSwrtTag  != TAG_FREE);

    // Selection: ready/free sets come from registered state only, so there is
    // no combinational path from any input to the issue slot.
    always_comb begin
        w_iss_found   = 1'b0;
        w_iss_idx     = '0;
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ready[i] = r_valid_q[i] && (r_qo_q[i] == TAG_FREE) && (r_qt_q[i] == TAG_FREE);
        end
        // Descending scan: the last hit written is the lowest index.
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_iss_found = 1'b1;
                w_iss_idx   = c_IDX_W'(i);
            end
            if (!r_valid_q[i]) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = c_IDX_W'(i);
            end
        end
    end

    assign w_load_ok = !r_alu_en_q || aluReady;
    assign w_issue   = w_load_ok && w_iss_found;
    assign w_accept  = dispEn && !r_full_q && w_alloc_found;

    // Dispatch bypass: operands whose producer broadcasts this cycle
    always_comb begin
        {w_disp_vo, w_disp_qo} = f_snoop(dispTagO, dispDataO, w_alu_hit, ALUwrtTag, ALUwrtData,
                                         w_ls_hit, LSwrtTag, LSwrtData);
        {w_disp_vt, w_disp_qt} = f_snoop(dispTagT, dispDataT, w_alu_hit, ALUwrtTag, ALUwrtData,
                                         w_ls_hit, LSwrtTag, LSwrtData);
    end

    // Entry next state: snoop, free on issue, allocate on dispatch
    always_comb begin
        w_valid_d = r_valid_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_op_d[i]    = r_op_q[i];
            w_vo_d[i]    = r_vo_q[i];
            w_qo_d[i]    = r_qo_q[i];
            w_vt_d[i]    = r_vt_q[i];
            w_qt_d[i]    = r_qt_q[i];
            w_dtag_d[i]  = r_dtag_q[i];
            w_dname_d[i] = r_dname_q[i];
            if (r_valid_q[i]) begin
                {w_vo_d[i], w_qo_d[i]} = f_snoop(r_qo_q[i], r_vo_q[i], w_alu_hit, ALUwrtTag,
                                                 ALUwrtData, w_ls_hit, LSwrtTag, LSwrtData);
                {w_vt_d[i], w_qt_d[i]} = f_snoop(r_qt_q[i], r_vt_q[i], w_alu_hit, ALUwrtTag,
                                                 ALUwrtData, w_ls_hit, LSwrtTag, LSwrtData);
            end
            if (w_issue && (w_iss_idx == c_IDX_W'(i))) begin
                w_valid_d[i] = 1'b0;
            end
            // Allocation targets a slot that was free before this edge, so it
            // never collides with the entry being issued.
            if (w_accept && (w_alloc_idx == c_IDX_W'(i))) begin
                w_valid_d[i] = 1'b1;
                w_op_d[i]    = dispOp;
                w_vo_d[i]    = w_disp_vo;
                w_qo_d[i]    = w_disp_qo;
                w_vt_d[i]    = w_disp_vt;
                w_qt_d[i]    = w_disp_qt;
                w_dtag_d[i]  = dispDestTag;
                w_dname_d[i] = dispDestName;
            end
        end
    end

    // Issue slot and occupancy next state
    always_comb begin
        w_alu_en_d    = r_alu_en_q;
        w_alu_op_d    = r_alu_op_q;
        w_alu_a_d     = r_alu_a_q;
        w_alu_b_d     = r_alu_b_q;
        w_alu_dtag_d  = r_alu_dtag_q;
        w_alu_dname_d = r_alu_dname_q;
        if (w_issue) begin
            w_alu_en_d    = 1'b1;
            w_alu_op_d    = r_op_q[w_iss_idx];
            w_alu_a_d     = r_vo_q[w_iss_idx];
            w_alu_b_d     = r_vt_q[w_iss_idx];
            w_alu_dtag_d  = r_dtag_q[w_iss_idx];
            w_alu_dname_d = r_dname_q[w_iss_idx];
        end else if (w_load_ok) begin
            w_alu_en_d = 1'b0;
        end
        w_count_d = r_count_q + c_CNT_W'(w_accept) - c_CNT_W'(w_issue);
        w_full_d  = (w_count_d == c_DEPTH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_q     <= '0;
            r_count_q     <= '0;
            r_full_q      <= 1'b0;
            r_alu_en_q    <= 1'b0;
            r_alu_op_q    <= '0;
            r_alu_a_q     <= '0;
            r_alu_b_q     <= '0;
            r_alu_dtag_q  <= '0;
            r_alu_dname_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_op_q[i]    <= '0;
                r_vo_q[i]    <= '0;
                r_qo_q[i]    <= TAG_FREE;
                r_vt_q[i]    <= '0;
                r_qt_q[i]    <= TAG_FREE;
                r_dtag_q[i]  <= '0;
                r_dname_q[i] <= '0;
            end
        end else begin
            r_valid_q     <= w_valid_d;
            r_count_q     <= w_count_d;
            r_full_q      <= w_full_d;
            r_alu_en_q    <= w_alu_en_d;
            r_alu_op_q    <= w_alu_op_d;
            r_alu_a_q     <= w_alu_a_d;
            r_alu_b_q     <= w_alu_b_d;
            r_alu_dtag_q  <= w_alu_dtag_d;
            r_alu_dname_q <= w_alu_dname_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_op_q[i]    <= w_op_d[i];
                r_vo_q[i]    <= w_vo_d[i];
                r_qo_q[i]    <= w_qo_d[i];
                r_vt_q[i]    <= w_vt_d[i];
                r_qt_q[i]    <= w_qt_d[i];
                r_dtag_q[i]  <= w_dtag_d[i];
                r_dname_q[i] <= w_dname_d[i];
            end
        end
    end

    assign rsFull      = r_full_q;
    assign aluEn       = r_alu_en_q;
    assign aluOp       = r_alu_op_q;
    assign aluA        = r_alu_a_q;
    assign aluB        = r_alu_b_q;
    assign aluDestTag  = r_alu_dtag_q;
    assign aluDestName = r_alu_dname_q;

endmodule
`default_nettype wire
